// File: rtl/jtcontra_pkg.sv
// jtcontra_pkg
//   Shared constants and types for the 007121 object path.
//   OBJ_BYTES     : bytes in one sprite table (64 sprites x 5 bytes)
//   OBJ_PAGE_BASE : object-RAM offset of the second sprite page
//   SCAN_AW       : address width of the private scan buffer
//   dma_state_e   : object DMA sequencer states
package jtcontra_pkg;

   localparam int          OBJ_BYTES     = 320;
   localparam logic [10:0] OBJ_PAGE_BASE = 11'h400;
   localparam int          SCAN_AW       = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COPY  = 2'd1,
      FLUSH = 2'd2
   } dma_state_e;

endpackage

// File: rtl/jtframe_dual_ram.sv
// jtframe_dual_ram
//   Inferred dual-port block RAM, one clock.
//   Port A: read/write (addr_a, data_a, we_a -> q_a)
//   Port B: read only  (addr_b -> q_b)
//   Both read ports are registered (1-cycle latency) and read-first: a read
//   of the address being written in the same cycle returns the old data.
//   rst clears only the output registers; memory contents are retained.
module jtframe_dual_ram #(
   parameter int AW = 9,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] data_a,
   input  logic          we_a,
   output logic [DW-1:0] q_a,
   input  logic [AW-1:0] addr_b,
   output logic [DW-1:0] q_b
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a] <= data_a;
      end
   end

   // Output registers sample the array before this cycle's write lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_a <= '0;
         q_b <= '0;
      end else begin
         q_a <= mem[addr_a];
         q_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/jtcontra_obj_dma.sv
// jtcontra_obj_dma
//   Object-RAM front end for the 007121 sprite path. Holds the 2 kB CPU
//   object RAM and, at each vertical-blank start, copies the active sprite
//   table into a private scan buffer read by the line renderer.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     LVBL                 : vertical blank (active low), falling edge = copy
//     obj_page             : source page select, sampled at copy start
//     cpu_addr/dout/we     : CPU access, writes qualified by obj_cs
//     obj_cs               : CPU chip select
//     cpu_din              : CPU read data (1-cycle latency)
//     scan_addr            : renderer byte address (bit 9 = out of range)
//     obj_scan             : renderer read data (1-cycle latency)
//     dma_busy             : copy in progress
//     dma_done             : single-cycle pulse when the copy completes
module jtcontra_obj_dma
   import jtcontra_pkg::*;
#(
   parameter int          OBJ_BYTES = jtcontra_pkg::OBJ_BYTES,
   parameter logic [10:0] PAGE_BASE = jtcontra_pkg::OBJ_PAGE_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        LVBL,
   input  logic        obj_page,
   input  logic [10:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_we,
   input  logic        obj_cs,
   output logic [7:0]  cpu_din,
   input  logic [9:0]  scan_addr,
   output logic [7:0]  obj_scan,
   output logic        dma_busy,
   output logic        dma_done
);

   dma_state_e         state_q, state_d;
   logic               last_lvbl_q, last_lvbl_d;
   logic               armed_q, armed_d;
   logic [8:0]         cnt_q, cnt_d;
   logic [10:0]        src_base_q, src_base_d;
   logic [SCAN_AW-1:0] wr_addr_q, wr_addr_d;
   logic               wr_en_q, wr_en_d;
   logic               done_q, done_d;
   logic               scan_hi_q, scan_hi_d;

   logic               vb_start;
   logic [10:0]        src_addr;
   logic [7:0]         dma_data;
   logic [7:0]         scan_q;
   logic [7:0]         scan_qa_unused;

   // armed_q blocks the first cycle after reset: LVBL may already be low
   // when reset releases and that must not be taken as a fresh blank.
   assign vb_start = armed_q & last_lvbl_q & ~LVBL;
   assign src_addr = src_base_q + {2'b00, cnt_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_lvbl_q <= 1'b1;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         src_base_q  <= '0;
         wr_addr_q   <= '0;
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;
         scan_hi_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_lvbl_q <= last_lvbl_d;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         src_base_q  <= src_base_d;
         wr_addr_q   <= wr_addr_d;
         wr_en_q     <= wr_en_d;
         done_q      <= done_d;
         scan_hi_q   <= scan_hi_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_lvbl_d = LVBL;
      armed_d     = 1'b1;
      cnt_d       = cnt_q;
      src_base_d  = src_base_q;
      // The buffer write trails the RAM read by one cycle, so the write
      // address is simply last cycle's read counter.
      wr_en_d     = (state_q == COPY);
      wr_addr_d   = cnt_q[SCAN_AW-1:0];
      done_d      = 1'b0;
      scan_hi_d   = scan_addr[9];

      case (state_q)
         IDLE: begin
         end
         COPY: begin
            if (cnt_q == 9'(OBJ_BYTES - 1)) begin
               state_d = FLUSH;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         FLUSH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new blank always wins, restarting any copy already under way.
      if (vb_start) begin
         state_d    = COPY;
         cnt_d      = '0;
         src_base_d = obj_page ? PAGE_BASE : 11'h000;
         done_d     = 1'b0;
      end
   end

   assign dma_busy = (state_q != IDLE);
   assign dma_done = done_q;
   assign obj_scan = scan_hi_q ? 8'h00 : scan_q;

   jtframe_dual_ram #(
      .AW (11),
      .DW (8)
   ) u_cpu_ram (
      .clk    (clk),
      .rst    (rst),
      .addr_a (cpu_addr),
      .data_a (cpu_dout),
      .we_a   (obj_cs & cpu_we),
      .q_a    (cpu_din),
      .addr_b (src_addr),
      .q_b    (dma_data)
   );

   jtframe_dual_ram #(
      .AW (SCAN_AW),
      .DW (8)
   ) u_scan_ram (
      .clk    (clk),
      .rst    (rst),
      .addr_a (wr_addr_q),
      .data_a (dma_data),
      .we_a   (wr_en_q),
      .q_a    (scan_qa_unused),
      .addr_b (scan_addr[SCAN_AW-1:0]),
      .q_b    (scan_q)
   );

endmodule

// File: tb/tb_jtcontra_obj_dma.sv
// tb_jtcontra_obj_dma
//   Bench for jtcontra_obj_dma: directed copy scenarios with literal
//   expectations, then a randomized phase, all shadowed by a frame-level
//   model (byte arrays plus a copy progress count) compared every cycle.
module tb_jtcontra_obj_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        LVBL = 1'b1;
   logic        obj_page = 1'b0;
   logic [10:0] cpu_addr = '0;
   logic [7:0]  cpu_dout = '0;
   logic        cpu_we = 1'b0;
   logic        obj_cs = 1'b0;
   logic [9:0]  scan_addr = '0;
   logic [7:0]  cpu_din;
   logic [7:0]  obj_scan;
   logic        dma_busy;
   logic        dma_done;

   always #5 clk = ~clk;

   jtcontra_obj_dma dut (
      .clk       (clk),
      .rst       (rst),
      .LVBL      (LVBL),
      .obj_page  (obj_page),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_we    (cpu_we),
      .obj_cs    (obj_cs),
      .cpu_din   (cpu_din),
      .scan_addr (scan_addr),
      .obj_scan  (obj_scan),
      .dma_busy  (dma_busy),
      .dma_done  (dma_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_cpu [2048];
   bit         m_cpu_k [2048];
   logic [7:0] m_buf [512];
   bit         m_buf_k [512];
   bit         m_active = 0, m_done = 0, m_last = 1, m_armed = 0, m_pend = 0, m_pk = 0;
   int         m_k = 0, m_src = 0, pend_idx = 0;
   logic [7:0] pend_val = '0;
   logic [7:0] m_scan = '0, m_din = '0;
   bit         m_scan_k = 0, m_din_k = 0;

   // Each edge of an active copy moves one byte from CPU RAM toward the
   // buffer; the byte lands in the buffer on the following edge. After 320
   // reads one more edge closes the copy with the done pulse.
   always @(posedge clk) begin
      if (rst) begin
         m_active = 0; m_done = 0; m_pend = 0; m_last = 1; m_armed = 0;
         m_scan = 8'h00; m_scan_k = 1; m_din = 8'h00; m_din_k = 1;
      end else begin
         m_scan_k = scan_addr[9] | m_buf_k[scan_addr[8:0]];
         m_scan   = scan_addr[9] ? 8'h00 : m_buf[scan_addr[8:0]];
         m_din_k  = m_cpu_k[cpu_addr];
         m_din    = m_cpu[cpu_addr];
         m_done   = 0;
         if (m_pend) begin
            m_buf[pend_idx]   = pend_val;
            m_buf_k[pend_idx] = m_pk;
         end
         m_pend = 0;
         if (m_active) begin
            if (m_k < 320) begin
               pend_idx = m_k;
               pend_val = m_cpu[m_src + m_k];
               m_pk     = m_cpu_k[m_src + m_k];
               m_pend   = 1;
               m_k++;
            end else begin
               m_active = 0;
               m_done   = 1;
            end
         end
         if (m_armed && m_last && !LVBL) begin
            m_active = 1; m_k = 0; m_done = 0;
            m_src = obj_page ? 1024 : 0;
         end
         m_last  = LVBL;
         m_armed = 1;
      end
      if (obj_cs && cpu_we) begin
         m_cpu[cpu_addr]   = cpu_dout;
         m_cpu_k[cpu_addr] = 1;
      end
   end

   always @(negedge clk) begin
      chk("busy_model", {31'd0, dma_busy}, {31'd0, m_active});
      chk("done_model", {31'd0, dma_done}, {31'd0, m_done});
      if (m_scan_k) chk("obj_scan_model", {24'd0, obj_scan}, {24'd0, m_scan});
      if (m_din_k)  chk("cpu_din_model", {24'd0, cpu_din}, {24'd0, m_din});
   end

   // ---------------- stimulus helpers ----------------
   task automatic read_scan(input logic [9:0] a, output logic [7:0] v);
      scan_addr = a;
      @(negedge clk);
      v = obj_scan;
   endtask

   // ev_kind: 0 none, 1 flip page, 2 CPU writes 0x77->0x100 and 0x11->0x010,
   // 3 reset pulse. ev_at is the cycle offset from the start edge E.
   task automatic run_copy(input bit page, input int ev_at, input int ev_kind,
                           output int busy_cnt, output int done_at);
      obj_page = page;
      LVBL     = 1'b0;
      busy_cnt = 0;
      done_at  = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (dma_busy) busy_cnt++;
         if (dma_done && done_at < 0) done_at = i;
         obj_cs = 0; cpu_we = 0; rst = 0;
         if (i == 5) LVBL = 1'b1;
         if (ev_kind == 1 && i == ev_at) obj_page = ~page;
         if (ev_kind == 2 && i == ev_at) begin
            obj_cs = 1; cpu_we = 1; cpu_addr = 11'h100; cpu_dout = 8'h77;
         end
         if (ev_kind == 2 && i == ev_at + 1) begin
            obj_cs = 1; cpu_we = 1; cpu_addr = 11'h010; cpu_dout = 8'h11;
         end
         if (ev_kind == 3 && i == ev_at) rst = 1;
      end
   endtask

   logic [7:0] v;
   logic [7:0] exp_b;
   int         bc, da;

   initial begin
      // Reset held four cycles.
      rst = 1;
      repeat (4) @(negedge clk);
      chk("rst_busy",     {31'd0, dma_busy}, 32'd0);
      chk("rst_done",     {31'd0, dma_done}, 32'd0);
      chk("rst_obj_scan", {24'd0, obj_scan}, 32'h00);
      chk("rst_cpu_din",  {24'd0, cpu_din},  32'h00);

      // LVBL low on the first cycle after release must not start a copy.
      rst  = 0;
      LVBL = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_copy", {31'd0, dma_busy}, 32'd0);
      end
      LVBL = 1;
      @(negedge clk);

      // Fill the whole CPU RAM: page 0 pattern, page 1 constant, random rest.
      for (int a = 0; a < 2048; a++) begin
         obj_cs = 1; cpu_we = 1; cpu_addr = 11'(a);
         if (a < 320)                    cpu_dout = 8'(a) ^ 8'h5A;
         else if (a >= 1024 && a < 1344) cpu_dout = 8'hC3;
         else                            cpu_dout = 8'($urandom);
         @(negedge clk);
      end
      obj_cs = 0; cpu_we = 0;
      cpu_addr = 11'h13F;
      @(negedge clk);
      chk("cpu_readback_13f", {24'd0, cpu_din}, 32'h65);

      // Page 0 copy.
      run_copy(1'b0, -1, 0, bc, da);
      $display("copy page0: busy_cycles=%0d done_at=E+%0d", bc, da);
      chk("p0_busy_cycles", bc, 32'd321);
      chk("p0_done_at", da, 32'd322);
      read_scan(10'h13F, v); chk("p0_scan_13f", {24'd0, v}, 32'h65);
      read_scan(10'h000, v); chk("p0_scan_000", {24'd0, v}, 32'h5A);
      read_scan(10'h200, v); chk("oor_scan_200", {24'd0, v}, 32'h00);
      read_scan(10'h004, v); chk("b2b_scan_004", {24'd0, v}, 32'h5E);

      // Page 1 copy, page flipped mid-copy.
      run_copy(1'b1, 100, 1, bc, da);
      $display("copy page1 (flip @E+100): busy_cycles=%0d done_at=E+%0d", bc, da);
      chk("p1_busy_cycles", bc, 32'd321);
      chk("p1_done_at", da, 32'd322);
      for (int a = 0; a < 320; a++) begin
         read_scan(10'(a), v);
         chk("p1_scan_byte", {24'd0, v}, 32'hC3);
      end

      // CPU writes during a page 0 copy.
      run_copy(1'b0, 50, 2, bc, da);
      $display("copy page0 with cpu writes @E+50: busy_cycles=%0d done_at=E+%0d", bc, da);
      chk("wr_done_at", da, 32'd322);
      read_scan(10'h100, v); chk("wr_ahead_100", {24'd0, v}, 32'h77);
      read_scan(10'h010, v); chk("wr_behind_010", {24'd0, v}, 32'h4A);

      // Reset in the middle of a copy, then a clean copy.
      run_copy(1'b0, 100, 3, bc, da);
      $display("copy page0 reset @E+100: busy_cycles=%0d done_at=%0d", bc, da);
      chk("rst_mid_busy_cycles", bc, 32'd100);
      chk("rst_mid_no_done", da, 32'hFFFF_FFFF);
      run_copy(1'b0, -1, 0, bc, da);
      $display("copy page0 after reset: busy_cycles=%0d done_at=E+%0d", bc, da);
      chk("rerun_done_at", da, 32'd322);
      for (int a = 0; a < 320; a++) begin
         if (a == 'h100)      exp_b = 8'h77;
         else if (a == 'h010) exp_b = 8'h11;
         else                 exp_b = 8'(a) ^ 8'h5A;
         read_scan(10'(a), v);
         chk("rerun_scan_byte", {24'd0, v}, {24'd0, exp_b});
      end

      // Randomized traffic: CPU accesses, renderer reads, blanks (with
      // restarts) and occasional resets, all checked against the model.
      for (int c = 0; c < 4000; c++) begin
         obj_cs    = ($urandom_range(0, 3) == 0);
         cpu_we    = $urandom_range(0, 1) == 1;
         cpu_addr  = 11'($urandom);
         cpu_dout  = 8'($urandom);
         scan_addr = 10'($urandom);
         obj_page  = $urandom_range(0, 1) == 1;
         LVBL      = ($urandom_range(0, 149) != 0);
         rst       = ($urandom_range(0, 1499) == 0);
         @(negedge clk);
      end
      obj_cs = 0; cpu_we = 0; rst = 0; LVBL = 1;
      repeat (400) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
